// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the request-unit state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    DATA,
    HALTED
  } ru_state_t;

endpackage

// File: rtl/request_unit_if.sv
// Request-unit bus bundle; REQUEST_UNIT_PERF_EN adds the icount/dwait counters.
interface request_unit_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t imemload;
  logic  dhit;
  logic  cu_dREN;
  logic  cu_dWEN;
  logic  cu_halt;
  word_t cu_daddr;
  word_t cu_dstore;

  logic  iREN;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  word_t instr;
  logic  pcEN;
  logic  halt;
`ifdef REQUEST_UNIT_PERF_EN
  word_t icount;
  word_t dwait;
`endif

  modport ru (
    input  ihit, imemload, dhit, cu_dREN, cu_dWEN, cu_halt, cu_daddr, cu_dstore,
    output iREN, dREN, dWEN, daddr, dstore, instr, pcEN, halt
`ifdef REQUEST_UNIT_PERF_EN
    , output icount, dwait
`endif
  );

  modport tb (
    output ihit, imemload, dhit, cu_dREN, cu_dWEN, cu_halt, cu_daddr, cu_dstore,
    input  iREN, dREN, dWEN, daddr, dstore, instr, pcEN, halt
`ifdef REQUEST_UNIT_PERF_EN
    , input icount, dwait
`endif
  );

endinterface

// File: rtl/ru_perf_counter.sv
// Saturating event counter: increments on en, sticks at all-ones until reset.
module ru_perf_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/request_unit.sv
// Memory request sequencer: fetch, decode, optional data access, sticky halt.
// REQUEST_UNIT_PERF_EN adds saturating retired-instruction and data-wait counters.
module request_unit
  import cpu_types_pkg::*;
(
  input logic        CLK,
  input logic        nRST,
  request_unit_if.ru ru
);

  ru_state_t state, state_next;
  word_t     instr_q, daddr_q, dstore_q;
  logic      rd_q, wr_q, pcen_q;
  logic      capture, pcen_next;
  logic      iren, dren, dwen;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    pcen_next  = 1'b0;
    iren       = 1'b0;
    dren       = 1'b0;
    dwen       = 1'b0;
    case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        iren = 1'b1;
        if (ru.ihit) state_next = EXEC;
      end
      EXEC: begin
        if (ru.cu_halt) begin
          state_next = HALTED;
        end else if (ru.cu_dREN || ru.cu_dWEN) begin
          capture    = 1'b1;
          state_next = DATA;
        end else begin
          pcen_next  = 1'b1;
          state_next = FETCH;
        end
      end
      DATA: begin
        // a simultaneous read+write request resolves to the write
        dwen = wr_q;
        dren = rd_q & ~wr_q;
        if (ru.dhit) begin
          pcen_next  = 1'b1;
          state_next = FETCH;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  // pcEN is registered so the strobe lands in the first cycle after completion
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr_q  <= '0;
      daddr_q  <= '0;
      dstore_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      pcen_q   <= 1'b0;
    end else begin
      pcen_q <= pcen_next;
      if ((state == FETCH) && ru.ihit) instr_q <= ru.imemload;
      if (capture) begin
        daddr_q  <= ru.cu_daddr;
        dstore_q <= ru.cu_dstore;
        rd_q     <= ru.cu_dREN;
        wr_q     <= ru.cu_dWEN;
      end
    end
  end

  assign ru.iREN   = iren;
  assign ru.dREN   = dren;
  assign ru.dWEN   = dwen;
  assign ru.pcEN   = pcen_q;
  assign ru.halt   = (state == HALTED);
  assign ru.instr  = instr_q;
  assign ru.daddr  = daddr_q;
  assign ru.dstore = dstore_q;

`ifdef REQUEST_UNIT_PERF_EN
  logic dwait_en;
  assign dwait_en = (state == DATA) && !ru.dhit;

  ru_perf_counter #(.WIDTH(32)) u_icount (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (pcen_q),
    .count (ru.icount)
  );

  ru_perf_counter #(.WIDTH(32)) u_dwait (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (dwait_en),
    .count (ru.dwait)
  );
`endif

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit; expected cycles are expanded from instruction plans.
module tb_request_unit;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  request_unit_if bus();

  request_unit u_dut (
    .CLK  (clk),
    .nRST (nrst),
    .ru   (bus)
  );

  logic       sat_en = 1'b0;
  logic [3:0] sat_cnt;

  ru_perf_counter #(.WIDTH(4)) u_sat (
    .clk   (clk),
    .rst_n (nrst),
    .en    (sat_en),
    .count (sat_cnt)
  );

  // one bus cycle: stimulus plus what the outputs must show during it
  typedef struct {
    logic        ihit;
    logic [31:0] imemload;
    logic        dhit;
    logic        cu_dren, cu_dwen, cu_halt;
    logic [31:0] cu_daddr, cu_dstore;
    logic [4:0]  exp_ctl;  // {iREN, dREN, dWEN, pcEN, halt}
    logic [31:0] exp_instr, exp_daddr, exp_dstore;
    int unsigned exp_icount, exp_dwait;
  } cyc_t;

  typedef struct {
    int unsigned fwait;
    logic [31:0] word;
    logic        rd, wr, hlt;
    logic [31:0] addr, data;
    int unsigned dw;
    logic        exp_rd, exp_wr;
  } ins_t;

  cyc_t q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] m_instr, m_daddr, m_dstore;
  logic        m_pc_pending, m_halted;
  int unsigned m_icount, m_dwait;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_instr = '0; m_daddr = '0; m_dstore = '0;
    m_pc_pending = 1'b0; m_halted = 1'b0;
    m_icount = 0; m_dwait = 0;
  endfunction

  function automatic cyc_t junk();
    cyc_t c;
    c.ihit      = 1'($urandom);
    c.imemload  = $urandom;
    c.dhit      = 1'($urandom);
    c.cu_dren   = 1'($urandom);
    c.cu_dwen   = 1'($urandom);
    c.cu_halt   = 1'($urandom);
    c.cu_daddr  = $urandom;
    c.cu_dstore = $urandom;
    c.exp_ctl   = '0;
    c.exp_instr = '0; c.exp_daddr = '0; c.exp_dstore = '0;
    c.exp_icount = 0; c.exp_dwait = 0;
    return c;
  endfunction

  function automatic void emit(cyc_t c, logic iren, logic dren, logic dwen, logic data_wait);
    c.exp_ctl    = {iren, dren, dwen, m_pc_pending, m_halted};
    c.exp_instr  = m_instr;
    c.exp_daddr  = m_daddr;
    c.exp_dstore = m_dstore;
    c.exp_icount = m_icount;
    c.exp_dwait  = m_dwait;
    q.push_back(c);
    if (m_pc_pending) m_icount++;
    m_pc_pending = 1'b0;
    if (data_wait) m_dwait++;
  endfunction

  // expand one instruction: fetch waits, ihit, decode, then halt / data access / retire
  function automatic void plan_instr(ins_t t);
    cyc_t c;
    for (int i = 0; i < int'(t.fwait); i++) begin
      c = junk(); c.ihit = 1'b0;
      emit(c, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    c = junk(); c.ihit = 1'b1; c.imemload = t.word;
    emit(c, 1'b1, 1'b0, 1'b0, 1'b0);
    m_instr = t.word;
    c = junk();
    c.cu_dren = t.rd; c.cu_dwen = t.wr; c.cu_halt = t.hlt;
    c.cu_daddr = t.addr; c.cu_dstore = t.data;
    emit(c, 1'b0, 1'b0, 1'b0, 1'b0);
    if (t.hlt) begin
      m_halted = 1'b1;
      return;
    end
    if (t.rd || t.wr) begin
      m_daddr = t.addr; m_dstore = t.data;
      for (int i = 0; i <= int'(t.dw); i++) begin
        c = junk(); c.dhit = (i == int'(t.dw));
        emit(c, 1'b0, t.exp_rd, t.exp_wr, i != int'(t.dw));
      end
    end
    m_pc_pending = 1'b1;
  endfunction

  function automatic void plan_idle_fetch(int unsigned n);
    cyc_t c;
    for (int i = 0; i < int'(n); i++) begin
      c = junk(); c.ihit = 1'b0;
      emit(c, 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endfunction

  function automatic void plan_halted(int unsigned n);
    for (int i = 0; i < int'(n); i++) emit(junk(), 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic drive(cyc_t c);
    bus.ihit = c.ihit; bus.imemload = c.imemload; bus.dhit = c.dhit;
    bus.cu_dREN = c.cu_dren; bus.cu_dWEN = c.cu_dwen; bus.cu_halt = c.cu_halt;
    bus.cu_daddr = c.cu_daddr; bus.cu_dstore = c.cu_dstore;
  endtask

  task automatic run_n(int unsigned n);
    cyc_t c;
    for (int unsigned i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      @(negedge clk);
      check("ctl", {27'b0, bus.iREN, bus.dREN, bus.dWEN, bus.pcEN, bus.halt}, {27'b0, c.exp_ctl});
      check("instr", bus.instr, c.exp_instr);
      check("daddr", bus.daddr, c.exp_daddr);
      check("dstore", bus.dstore, c.exp_dstore);
`ifdef REQUEST_UNIT_PERF_EN
      check("icount", bus.icount, c.exp_icount);
      check("dwait", bus.dwait, c.exp_dwait);
`endif
      drive(c);
    end
  endtask

  task automatic run_queue();
    run_n(q.size());
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctl", {27'b0, bus.iREN, bus.dREN, bus.dWEN, bus.pcEN, bus.halt}, 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_daddr", bus.daddr, 32'h0);
    check("rst_dstore", bus.dstore, 32'h0);
`ifdef REQUEST_UNIT_PERF_EN
    check("rst_icount", bus.icount, 32'h0);
    check("rst_dwait", bus.dwait, 32'h0);
`endif
    q.delete();
    model_reset();
    nrst = 1'b1;
  endtask

  ins_t tbl[5];
  ins_t t;

  initial begin
    drive(junk());
    bus.ihit = 1'b0; bus.dhit = 1'b0;
    model_reset();

    tbl[0] = '{0, 32'h2001000A, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 0, 1'b0, 1'b0};
    tbl[1] = '{1, 32'h8C220000, 1'b1, 1'b0, 1'b0, 32'h00000F00, 32'h00000000, 2, 1'b1, 1'b0};
    tbl[2] = '{0, 32'hAC230004, 1'b1, 1'b1, 1'b0, 32'h00000100, 32'hDEADBEEF, 3, 1'b0, 1'b1};
    tbl[3] = '{2, 32'hAC240008, 1'b0, 1'b1, 1'b0, 32'h00000200, 32'h12345678, 2, 1'b0, 1'b1};
    tbl[4] = '{2, 32'h00851020, 1'b0, 1'b0, 1'b0, 32'h00000300, 32'h0000AAAA, 0, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 5; i++) plan_instr(tbl[i]);
    plan_idle_fetch(2);
    run_queue();
    @(negedge clk);
`ifdef REQUEST_UNIT_PERF_EN
    check("icount_5", bus.icount, 32'd5);
    check("dwait_7", bus.dwait, 32'd7);
`endif

    // saturating counter on a narrow instance
    check("sat_start", {28'b0, sat_cnt}, 32'd0);
    sat_en = 1'b1;
    repeat (10) @(negedge clk);
    check("sat_10", {28'b0, sat_cnt}, 32'd10);
    repeat (10) @(negedge clk);
    check("sat_hold", {28'b0, sat_cnt}, 32'd15);
    sat_en = 1'b0;

    // halt beats a simultaneous write, then absorbs ihit/dhit
    do_reset();
    t = '{1, 32'h0000000C, 1'b0, 1'b1, 1'b1, 32'h00000300, 32'h00000055, 0, 1'b0, 1'b0};
    plan_instr(t);
    plan_halted(6);
    run_queue();

    // reset dropped in the middle of a load
    do_reset();
    t = '{0, 32'h8C2500A0, 1'b1, 1'b0, 1'b0, 32'h000000A0, 32'h00000000, 6, 1'b1, 1'b0};
    plan_instr(t);
    run_n(4);
    @(posedge clk);
    #2;
    check("pre_rst_dren", {31'b0, bus.dREN}, 32'd1);
    nrst = 1'b0;
    #1;
    check("async_drop", {28'b0, bus.iREN, bus.dREN, bus.dWEN, bus.pcEN}, 32'h0);
    do_reset();
    plan_idle_fetch(1);
    run_queue();

    // randomized instruction streams
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int k = 0; k < 20; k++) begin
        int unsigned kind;
        kind = $urandom_range(0, 9);
        t.fwait = $urandom_range(0, 3);
        t.word  = $urandom;
        t.rd    = (kind == 5 || kind == 6 || kind == 9);
        t.wr    = (kind == 7 || kind == 8 || kind == 9);
        t.hlt   = 1'b0;
        t.addr  = $urandom;
        t.data  = $urandom;
        t.dw    = $urandom_range(0, 4);
        t.exp_wr = t.wr;
        t.exp_rd = t.rd && !t.wr;
        plan_instr(t);
      end
      if (seg % 2 == 0) begin
        t.fwait = $urandom_range(0, 2);
        t.word  = $urandom;
        t.rd    = 1'($urandom);
        t.wr    = 1'($urandom);
        t.hlt   = 1'b1;
        t.addr  = $urandom;
        t.data  = $urandom;
        plan_instr(t);
        plan_halted(5);
      end else begin
        plan_idle_fetch(2);
      end
      run_queue();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/request_unit.md
REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK and nRST.
REQ-002 CLK  in  1  system clock, rising edge.
REQ-003 nRST  in  1  asynchronous active-low reset.
REQ-004 ihit  in  1  instruction memory read complete; imemload valid this cycle.
REQ-005 imemload  in  32 (word_t)  fetched instruction word.
REQ-006 dhit  in  1  data memory access complete.
REQ-007 cu_dREN, cu_dWEN, cu_halt  in  1 each  control unit requests for the latched instruction.
REQ-008 cu_daddr, cu_dstore  in  32 each  control unit data address and store data.
REQ-009 iREN  out  1  instruction read request.
REQ-010 dREN, dWEN  out  1 each  data read and write requests.
REQ-011 daddr, dstore  out  32 each  registered data address and store data.
REQ-012 instr  out  32  latched instruction presented to the control unit.
REQ-013 pcEN  out  1  one-cycle PC advance strobe.
REQ-014 halt  out  1  sticky halt indication.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, EXEC, DATA and HALTED; outputs iREN, dREN, dWEN and pcEN SHALL be Moore-decoded from the state.
REQ-016 IDLE SHALL drive all request and strobe outputs 0 and move to FETCH on the next edge.
REQ-017 FETCH SHALL assert iREN; on ihit it SHALL load instr <= imemload and go to EXEC; dhit in FETCH SHALL be ignored.
REQ-018 EXEC SHALL give the control unit one decode cycle with no memory request, then branch on the control unit requests.
REQ-019 If cu_halt=1, EXEC SHALL go to HALTED; this takes priority over any data request.
REQ-020 Otherwise, if cu_dREN or cu_dWEN is set, EXEC SHALL capture daddr <= cu_daddr and dstore <= cu_dstore and go to DATA.
REQ-021 Otherwise, EXEC SHALL assert pcEN for exactly one cycle and go to FETCH.
REQ-022 DATA SHALL hold dWEN=captured cu_dWEN and dREN=captured cu_dREN AND NOT cu_dWEN; if both were requested, the write wins.
REQ-023 On dhit, DATA SHALL pulse pcEN for one cycle and go to FETCH; ihit in DATA SHALL be ignored.
REQ-024 dREN and dWEN SHALL never both be 1, and iREN SHALL never be 1 in the same cycle as either of them.
REQ-025 HALTED SHALL be absorbing until reset; halt=1 and all requests are 0 in HALTED.
REQ-026 Latency: a non-memory instruction SHALL take the ihit cycle plus one EXEC cycle; a load or store SHALL additionally take every DATA cycle through dhit.
REQ-027 daddr, dstore and instr SHALL hold their values except at the capture points in REQ-017 and REQ-020.

Reset
REQ-028 While nRST=0, the state SHALL be IDLE; instr, daddr, dstore, halt and pcEN SHALL be 0; iREN, dREN and dWEN SHALL be 0.
REQ-029 A reset asserted mid-DATA or mid-FETCH SHALL immediately drop all requests, with no completion strobe.

Configuration
REQ-030 With REQUEST_UNIT_PERF_EN defined, the block SHALL add two 32-bit saturating outputs, icount and dwait.
REQ-031 icount SHALL count pcEN pulses; dwait SHALL count DATA cycles with dhit=0; both SHALL reset to 0 and hold at 32'hFFFFFFFF.
REQ-032 Without REQUEST_UNIT_PERF_EN, these ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-033 word_t and the state enum ru_state_t SHALL live in cpu_types_pkg.
REQ-034 The ports SHALL be bundled in request_unit_if, with modport ru for this block and modport tb for the bench.
REQ-035 The counters SHALL be one sub-module, ru_perf_counter, instantiated twice and only under the macro.

Verification
REQ-036 Release reset; ihit=1 with imemload=32'h2001000A on the first FETCH cycle -> instr=32'h2001000A, one EXEC cycle, pcEN pulse, then iREN=1 again.
REQ-037 Load: EXEC with cu_dREN=1 and cu_daddr=32'h00000F00; dhit after 3 cycles -> dREN=1 for exactly 3 cycles, daddr=32'h00000F00, then pcEN pulse.
REQ-038 Both requests: cu_dREN=1 and cu_dWEN=1 with cu_dstore=32'hDEADBEEF -> dWEN=1, dREN=0, dstore=32'hDEADBEEF.
REQ-039 Halt: cu_halt=1 together with cu_dWEN=1 in EXEC -> HALTED, halt=1 and no dWEN; later ihit/dhit pulses leave all outputs unchanged.
REQ-040 Drop nRST during DATA -> dREN/dWEN fall asynchronously, no pcEN pulse; after release, iREN rises one cycle after IDLE.
REQ-041 With the macro defined: 5 instructions and 7 dhit-less DATA cycles -> icount=5, dwait=7; a forced saturation stays at 32'hFFFFFFFF.
